// File: rtl/spi_master_multi.sv
// SPI master with all four CPOL/CPHA modes, a runtime SCK divider, NUM_CS chip
// selects and independent TX/RX phase lengths inside one chip-select frame.
module spi_master_multi #(
    parameter int MAX_TX_BITS = 16,
    parameter int MAX_RX_BITS = 16,
    parameter int NUM_CS      = 4,
    parameter int DIV_W       = 8,
    localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int TXL_W      = $clog2(MAX_TX_BITS + 1),
    localparam int RXL_W      = $clog2(MAX_RX_BITS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic [CS_W-1:0]        cs_sel,
    input  logic                   cpol,
    input  logic                   cpha,
    input  logic [DIV_W-1:0]       half_period,
    input  logic [TXL_W-1:0]       tx_len,
    input  logic [RXL_W-1:0]       rx_len,
    input  logic [MAX_TX_BITS-1:0] tx_data,
    output logic [MAX_RX_BITS-1:0] rx_data,
    output logic                   spi_clk,
    output logic                   spi_mosi,
    input  logic                   spi_miso,
    output logic [NUM_CS-1:0]      spi_cs_n
);

    // One extra bit so tx_len + rx_len never wraps; edge index covers 2*N.
    localparam int N_W = ((TXL_W > RXL_W) ? TXL_W : RXL_W) + 1;
    localparam int E_W = N_W + 1;

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t                 state;
    state_t                 next_state;

    logic [DIV_W-1:0]       h_q;
    logic [DIV_W-1:0]       cnt;
    logic [N_W-1:0]         n_q;
    logic [E_W-1:0]         ec;
    logic [E_W-1:0]         two_n;
    logic                   cpol_q;
    logic                   cpha_q;
    logic [RXL_W-1:0]       rx_len_q;
    logic [MAX_TX_BITS-1:0] tx_sr;
    logic [MAX_RX_BITS-1:0] rx_sr;

    logic [N_W-1:0]         n_in;
    logic [DIV_W-1:0]       h_in;
    logic [MAX_TX_BITS-1:0] tx_masked;
    logic [NUM_CS-1:0]      cs_dec;
    logic                   accept;
    logic                   half_end;
    logic                   last_half;
    logic                   toggle;
    logic                   sample;
    logic                   mosi_step;
    logic                   frame_end;

    assign busy  = (state != IDLE);
    assign two_n = {n_q, 1'b0};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:  if (accept)                 next_state = (n_in == '0) ? GAP : SETUP;
            SETUP: if (half_end)               next_state = XFER;
            XFER:  if (half_end && last_half)  next_state = HOLD;
            HOLD:  if (half_end)               next_state = GAP;
            GAP:   if (half_end)               next_state = IDLE;
            default:                           next_state = IDLE;
        endcase
    end

    // Event decode: ec counts SCK toggles already made, so its LSB tells
    // leading (even) from trailing (odd) for the next one.
    always_comb begin
        n_in      = N_W'(tx_len) + N_W'(rx_len);
        h_in      = (half_period == '0) ? DIV_W'(1) : half_period;
        tx_masked = tx_data & ~({MAX_TX_BITS{1'b1}} >> tx_len);
        cs_dec    = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(cs_sel) == i) cs_dec[i] = 1'b0;
        end
        accept    = (state == IDLE) && start;
        half_end  = (cnt == h_q - DIV_W'(1));
        last_half = (ec == two_n);
        toggle    = half_end && ((state == SETUP) || ((state == XFER) && !last_half));
        sample    = toggle && (ec[0] == cpha_q);
        mosi_step = toggle && (cpha_q ? !ec[0] : (ec[0] && (ec != two_n - E_W'(1))));
        frame_end = (state == GAP) && half_end;
    end

    // Datapath and registered pin drivers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            done     <= 1'b0;
            rx_data  <= '0;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_cs_n <= '1;
            h_q      <= DIV_W'(1);
            cnt      <= '0;
            n_q      <= '0;
            ec       <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            rx_len_q <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                // An empty frame runs a one-cycle GAP with CS untouched.
                h_q      <= (n_in == '0) ? DIV_W'(1) : h_in;
                n_q      <= n_in;
                cpol_q   <= cpol;
                cpha_q   <= cpha;
                rx_len_q <= rx_len;
                cnt      <= '0;
                ec       <= '0;
                rx_sr    <= '0;
                spi_clk  <= cpol;
                spi_cs_n <= (n_in == '0) ? '1 : cs_dec;
                if (!cpha && (n_in != '0)) begin
                    spi_mosi <= tx_masked[MAX_TX_BITS-1];
                    tx_sr    <= tx_masked << 1;
                end else begin
                    tx_sr    <= tx_masked;
                end
            end else if (busy) begin
                cnt <= half_end ? '0 : cnt + DIV_W'(1);
                if (toggle) begin
                    spi_clk <= ~spi_clk;
                    ec      <= ec + E_W'(1);
                end
                if (sample) begin
                    rx_sr <= {rx_sr[MAX_RX_BITS-2:0], spi_miso};
                end
                if (mosi_step) begin
                    spi_mosi <= tx_sr[MAX_TX_BITS-1];
                    tx_sr    <= tx_sr << 1;
                end
                if ((state == HOLD) && half_end) begin
                    spi_cs_n <= '1;
                    spi_clk  <= cpol_q;
                end
                if (frame_end) begin
                    done     <= 1'b1;
                    spi_mosi <= 1'b0;
                    rx_data  <= rx_sr & ~({MAX_RX_BITS{1'b1}} << rx_len_q);
                end
            end
        end
    end

endmodule
